// File: rtl/ctrl_pkg.sv
// Shared state codes and control-word constants for the sequencing FSM,
// so the datapath and monitors decode them identically.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        LOAD  = 3'b001,
        EXA   = 3'b010,
        EXB1  = 3'b011,
        EXB2  = 3'b100,
        STORE = 3'b101,
        DONE  = 3'b110
    } state_t;

    localparam logic [4:0] CS_IDLE  = 5'b00000;
    localparam logic [4:0] CS_LOAD  = 5'b00001;
    localparam logic [4:0] CS_EXA   = 5'b00010;
    localparam logic [4:0] CS_EXB1  = 5'b00100;
    localparam logic [4:0] CS_EXB2  = 5'b00110;
    localparam logic [4:0] CS_STORE = 5'b01000;
    localparam logic [4:0] CS_DONE  = 5'b10000;

endpackage

// File: rtl/control_unit.sv
// Moore sequencing FSM: latches the op mode on start, walks the fixed
// sequence for that mode and decodes a 5-bit control word from the state.
module control_unit
    import ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       mode,
    output logic [4:0] cs,
    output logic [2:0] state
);

    state_t state_q;
    state_t state_d;
    logic   mode_q;
    logic   mode_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // start/mode are only looked at in IDLE and DONE; elsewhere the sequence runs on.
    always_comb begin
        state_d = IDLE;
        mode_d  = mode_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    mode_d  = mode;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD:    state_d = mode_q ? EXB1 : EXA;
            EXA:     state_d = STORE;
            EXB1:    state_d = EXB2;
            EXB2:    state_d = STORE;
            STORE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cs = CS_IDLE;
        case (state_q)
            LOAD:    cs = CS_LOAD;
            EXA:     cs = CS_EXA;
            EXB1:    cs = CS_EXB1;
            EXB2:    cs = CS_EXB2;
            STORE:   cs = CS_STORE;
            DONE:    cs = CS_DONE;
            default: cs = CS_IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: vector table, hand-written corner sequences and
// randomized stimulus checked against a sequence-list reference model.
module tb_control_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       mode  = 1'b0;
    logic [4:0] cs;
    logic [2:0] state;

    int unsigned errors = 0;
    int unsigned checks = 0;

    control_unit dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .mode (mode),
        .cs   (cs),
        .state(state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       r;
        logic       s;
        logic       m;
        logic [2:0] exp_state;
        logic [4:0] exp_cs;
    } vec_t;

    vec_t vecs [20];

    // Control word expected for each state code (index 7 is the illegal code).
    logic [4:0] cs_of [8];

    // Reference model: an op is the list of states it will visit after the start edge.
    int unsigned plan [$];
    int unsigned mcur = 0;

    task automatic check(input string name, input logic [2:0] st, input logic [4:0] c);
        checks = checks + 1;
        if (state !== st) begin
            errors = errors + 1;
            $display("FAIL %s: state got %b expected %b", name, state, st);
        end
        checks = checks + 1;
        if (cs !== c) begin
            errors = errors + 1;
            $display("FAIL %s: cs got %b expected %b", name, cs, c);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic m);
        reset = r;
        start = s;
        mode  = m;
        @(posedge clock);
        #1;
    endtask

    task automatic model_edge(input logic r, input logic s, input logic m);
        if (r) begin
            plan.delete();
            mcur = 0;
        end else if (plan.size() != 0) begin
            mcur = plan.pop_front();
        end else if ((mcur == 0 || mcur == 6) && s) begin
            if (m) plan = '{1, 3, 4, 5, 6};
            else   plan = '{1, 2, 5, 6};
            mcur = plan.pop_front();
        end else begin
            mcur = 0;
        end
    endtask

    initial begin
        cs_of = '{5'b00000, 5'b00001, 5'b00010, 5'b00100,
                  5'b00110, 5'b01000, 5'b10000, 5'b00000};

        // reset hold, mode 0 back-to-back into mode 1, then drop start during EXA
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'b000, 5'b00000};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 3'b000, 5'b00000};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 3'b000, 5'b00000};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 3'b001, 5'b00001};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 3'b010, 5'b00010};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 3'b101, 5'b01000};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 3'b110, 5'b10000};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 3'b001, 5'b00001};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 3'b011, 5'b00100};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 3'b100, 5'b00110};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 3'b101, 5'b01000};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 3'b110, 5'b10000};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 3'b000, 5'b00000};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 3'b000, 5'b00000};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 3'b001, 5'b00001};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 3'b010, 5'b00010};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 3'b101, 5'b01000};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 3'b110, 5'b10000};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 3'b000, 5'b00000};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 3'b000, 5'b00000};

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].r, vecs[i].s, vecs[i].m);
            check($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_cs);
        end

        // mode flipped during EXB1 must not alter the long sequence
        step(1'b1, 1'b0, 1'b0); check("mflip_rst",   3'b000, 5'b00000);
        step(1'b0, 1'b1, 1'b1); check("mflip_load",  3'b001, 5'b00001);
        step(1'b0, 1'b0, 1'b1); check("mflip_exb1",  3'b011, 5'b00100);
        step(1'b0, 1'b0, 1'b0); check("mflip_exb2",  3'b100, 5'b00110);
        step(1'b0, 1'b0, 1'b0); check("mflip_store", 3'b101, 5'b01000);
        step(1'b0, 1'b0, 1'b0); check("mflip_done",  3'b110, 5'b10000);
        step(1'b0, 1'b0, 1'b0); check("mflip_idle",  3'b000, 5'b00000);

        // reset during EXA with start held, then restart
        step(1'b0, 1'b1, 1'b0); check("rexa_load",  3'b001, 5'b00001);
        step(1'b0, 1'b1, 1'b0); check("rexa_exa",   3'b010, 5'b00010);
        step(1'b1, 1'b1, 1'b0); check("rexa_rst",   3'b000, 5'b00000);
        step(1'b0, 1'b1, 1'b1); check("rexa_load2", 3'b001, 5'b00001);
        step(1'b0, 1'b1, 1'b0); check("rexa_exb1",  3'b011, 5'b00100);
        step(1'b0, 1'b1, 1'b0); check("rexa_exb2",  3'b100, 5'b00110);
        // reset during EXB2
        step(1'b1, 1'b1, 1'b0); check("rexb2_rst",  3'b000, 5'b00000);
        step(1'b0, 1'b1, 1'b0); check("rexb2_load", 3'b001, 5'b00001);
        step(1'b0, 1'b0, 1'b1); check("rexb2_exa",  3'b010, 5'b00010);

        // randomized run against the reference model
        step(1'b1, 1'b0, 1'b0);
        model_edge(1'b1, 1'b0, 1'b0);
        check("rnd_rst", mcur[2:0], cs_of[mcur]);
        for (int i = 0; i < 400; i++) begin
            logic r, s, m;
            r = ($urandom_range(0, 24) == 0);
            s = ($urandom_range(0, 3) != 0);
            m = 1'($urandom_range(0, 1));
            step(r, s, m);
            model_edge(r, s, m);
            check($sformatf("rnd%0d", i), mcur[2:0], cs_of[mcur]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
